// File: rtl/inst_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package inst_fetch_responder_pkg;

    localparam int unsigned InstAddrW = 32;
    localparam int unsigned InstW     = 32;
    localparam int unsigned ByteW     = 8;
    localparam int unsigned WordBytes = 4;
    localparam int unsigned CntW      = 3;   // wide enough to reach WordBytes

    typedef logic [InstAddrW-1:0] inst_addr_bus_t;
    typedef logic [InstW-1:0]     inst_bus_t;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    localparam logic      True_v   = 1'b1;
    localparam logic      False_v  = 1'b0;
    localparam inst_bus_t ZeroWord = '0;

    // Payload written into the hold register when a fetch completes.
    typedef struct packed {
        logic           valid;
        inst_addr_bus_t tag;
        inst_bus_t      data;
    } hold_wr_t;

    // True when two byte addresses fall in the same aligned 32-bit word.
    function automatic logic same_word(input inst_addr_bus_t a, input inst_addr_bus_t b);
        return a[InstAddrW-1:2] == b[InstAddrW-1:2];
    endfunction

endpackage

// File: rtl/inst_fetch_responder_hold_reg.sv
// One-word tagged hold register: hit compare, store-invalidate and a
// completion write port. The data register drives the fetch result directly.
module inst_hold_reg
    import inst_fetch_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [InstAddrW-1:0] lookup_addr_i,
    output logic                 hit_c_o,
    input  logic                 inv_valid_i,
    input  logic [InstAddrW-1:0] inv_addr_i,
    input  logic                 wr_en_i,
    input  hold_wr_t             wr_i,
    output logic [InstW-1:0]     data_o
);

    inst_addr_bus_t tag_q;
    logic           valid_q;
    inst_bus_t      data_q;
    logic           inv_match_c;

    always_comb begin
        hit_c_o     = valid_q & (lookup_addr_i == tag_q);
        inv_match_c = inv_valid_i & same_word(inv_addr_i, tag_q);
    end

    // A completion overrides any stale-tag invalidate; the writer already
    // folds invalidates against the new tag into wr_i.valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            valid_q <= False_v;
            data_q  <= ZeroWord;
        end else if (wr_en_i) begin
            tag_q   <= wr_i.tag;
            valid_q <= wr_i.valid;
            data_q  <= wr_i.data;
        end else if (inv_match_c) begin
            valid_q <= False_v;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: assembles a little-endian word from four
// byte reads of a synchronous program RAM, fronted by a one-word hold register.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 ram_inst_re,
    input  logic [InstAddrW-1:0] ram_inst_addr,
    output logic                 ram_inst_busy,
    output logic [InstW-1:0]     ram_inst,
    input  logic [ByteW-1:0]     mem_din,
    output logic [ADDR_W-1:0]    mem_a,
    output logic                 mem_wr,
    input  logic                 bus_hold,
    output logic                 bus_busy,
    input  logic                 inv_valid,
    input  logic [InstAddrW-1:0] inv_addr
);

    typedef logic [ADDR_W-1:0] ram_addr_bus_t;

    fetch_state_e    state_q;
    inst_addr_bus_t  addr_q;
    logic [CntW-1:0] issue_cnt_q;
    logic [1:0]      cap_cnt_q;
    logic [RD_LAT-1:0] iss_pipe_q;
    logic [RD_LAT-1:0] iss_pipe_d;
    inst_bus_t       word_q;
    logic            inv_pend_q;

    logic           hit_c;
    logic           miss_c;
    logic           accept_c;
    logic           abort_c;
    logic           issue_c;
    logic           capture_c;
    logic           done_c;
    logic           inv_fetch_c;
    inst_addr_bus_t fetch_addr_c;
    inst_bus_t      word_ins_c;
    hold_wr_t       hold_wr_c;

    inst_hold_reg u_hold (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_addr_i (ram_inst_addr),
        .hit_c_o       (hit_c),
        .inv_valid_i   (inv_valid),
        .inv_addr_i    (inv_addr),
        .wr_en_i       (done_c),
        .wr_i          (hold_wr_c),
        .data_o        (ram_inst)
    );

    // Request decode, byte-issue/capture strobes and word assembly.
    always_comb begin
        miss_c       = ram_inst_re & ~hit_c;
        accept_c     = (state_q == FETCH_IDLE) & miss_c & rdy & ~bus_hold;
        abort_c      = (state_q == FETCH_RUN) & ~rdy;
        issue_c      = accept_c
                     | ((state_q == FETCH_RUN) & rdy & (issue_cnt_q < CntW'(WordBytes)));
        capture_c    = (state_q == FETCH_RUN) & rdy & iss_pipe_q[RD_LAT-1];
        done_c       = capture_c & (cap_cnt_q == 2'd3);
        fetch_addr_c = (state_q == FETCH_IDLE) ? ram_inst_addr : addr_q;
        inv_fetch_c  = inv_valid & same_word(inv_addr, fetch_addr_c);

        word_ins_c = word_q;
        word_ins_c[{cap_cnt_q, 3'b000} +: ByteW] = mem_din;

        // A store to the word being fetched, now or earlier, wins over the fill.
        hold_wr_c.valid = ~(inv_pend_q | inv_fetch_c);
        hold_wr_c.tag   = addr_q;
        hold_wr_c.data  = word_ins_c;

        iss_pipe_d    = '0;
        iss_pipe_d[0] = issue_c;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            iss_pipe_d[i] = iss_pipe_q[i-1];
        end
        if (abort_c) begin
            iss_pipe_d = '0;
        end
    end

    // Outputs seen by the fetch stage and the RAM in the request cycle.
    always_comb begin
        ram_inst_busy = (state_q != FETCH_IDLE) | (miss_c & rst_n);
        bus_busy      = (state_q != FETCH_IDLE);
        mem_wr        = False_v;
        if (!rst_n) begin
            mem_a = '0;
        end else if (state_q == FETCH_IDLE) begin
            mem_a = ram_inst_addr[ADDR_W-1:0];
        end else begin
            mem_a = ram_addr_bus_t'(addr_q[ADDR_W-1:0] + ADDR_W'(issue_cnt_q));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH_IDLE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            iss_pipe_q  <= '0;
            word_q      <= ZeroWord;
            inv_pend_q  <= False_v;
        end else begin
            iss_pipe_q <= iss_pipe_d;
            case (state_q)
                FETCH_IDLE: begin
                    if (accept_c) begin
                        state_q     <= FETCH_RUN;
                        addr_q      <= ram_inst_addr;
                        issue_cnt_q <= CntW'(1);
                        cap_cnt_q   <= '0;
                        word_q      <= ZeroWord;
                        inv_pend_q  <= inv_fetch_c;
                    end
                end
                FETCH_RUN: begin
                    if (abort_c) begin
                        state_q     <= FETCH_IDLE;
                        issue_cnt_q <= '0;
                        cap_cnt_q   <= '0;
                        word_q      <= ZeroWord;
                        inv_pend_q  <= False_v;
                    end else if (done_c) begin
                        state_q     <= FETCH_IDLE;
                        issue_cnt_q <= '0;
                        cap_cnt_q   <= '0;
                        inv_pend_q  <= False_v;
                    end else begin
                        if (issue_cnt_q < CntW'(WordBytes)) begin
                            issue_cnt_q <= issue_cnt_q + CntW'(1);
                        end
                        if (capture_c) begin
                            word_q    <= word_ins_c;
                            cap_cnt_q <= cap_cnt_q + 2'd1;
                        end
                        if (inv_fetch_c) begin
                            inv_pend_q <= True_v;
                        end
                    end
                end
                default: state_q <= FETCH_IDLE;
            endcase
        end
    end

endmodule
